// File: rtl/nv_ram_rwsp_prm.sv
// Parametrised single-read/single-write synchronous RAM with a post-reset zero sweep and a two-stage read pipeline.
// Optional write-to-read forwarding on output-register collisions: define NV_RAM_RWSP_BYPASS_EN.
module nv_ram_rwsp_prm #(
  parameter int DEPTH = 61,
  parameter int WIDTH = 514,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    ra,
  input  logic             re,
  input  logic             ore,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  input  logic [AW-1:0]    wa,
  input  logic             we,
  input  logic [WIDTH-1:0] di,
  output logic             init_busy,
  output logic             oob_err,
  input  logic [31:0]      pwrbus_ram_pd
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IC = AW'(DEPTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [AW-1:0]    r_ic;
  logic [AW-1:0]    r_ra_d;
  logic             r_ra_ok;
  logic             r_ra_ld;
  logic             r_oob;
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_vld;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_run;
  logic             w_wa_ok;
  logic             w_ra_ok;
  logic             w_wr_ok;
  logic [WIDTH-1:0] w_rd_word;
  logic             w_unused_pd;

  assign w_run   = (r_state == ST_RUN);
  assign w_wa_ok = ({1'b0, wa} < DEPTH_W);
  assign w_ra_ok = ({1'b0, ra} < DEPTH_W);
  assign w_wr_ok = w_run && we && w_wa_ok;

`ifdef NV_RAM_RWSP_BYPASS_EN
  // Write-first: a write landing on the word being output is forwarded straight to dout.
  assign w_rd_word = (we && (wa == r_ra_d)) ? di : r_mem[r_ra_d];
`else
  assign w_rd_word = r_mem[r_ra_d];
`endif

  // Power-down bus has no functional effect in this model.
  assign w_unused_pd = ^pwrbus_ram_pd;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) r_state <= ST_INIT;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: defaults first so no path through the block leaves a signal unassigned (no latch).
    w_state_nxt = r_state;
    init_busy   = 1'b0;
    case (r_state)
      ST_INIT: begin
        init_busy = 1'b1;
        if (r_ic == LAST_IC) w_state_nxt = ST_RUN;
      end
      default: ;
    endcase
  end

  // NOTE: the array has no reset branch; the INIT sweep zeroes it so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!w_run)       r_mem[r_ic] <= '0;
      else if (w_wr_ok) r_mem[wa]   <= di;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ic       <= '0;
      r_ra_d     <= '0;
      r_ra_ok    <= 1'b0;
      r_ra_ld    <= 1'b0;
      r_oob      <= 1'b0;
      r_dout     <= '0;
      r_dout_vld <= 1'b0;
    end else if (!w_run) begin
      r_ic <= r_ic + AW'(1);
    end else begin
      if (re) begin
        r_ra_d  <= ra;
        r_ra_ok <= w_ra_ok;
        r_ra_ld <= 1'b1;
      end
      if (ore) begin
        r_dout     <= r_ra_ok ? w_rd_word : '0;
        r_dout_vld <= r_ra_ld;
      end
      if ((we && !w_wa_ok) || (re && !w_ra_ok)) r_oob <= 1'b1;
    end
  end

  assign dout     = r_dout;
  assign dout_vld = r_dout_vld;
  assign oob_err  = r_oob;

endmodule

// File: tb/tb_nv_ram_rwsp_prm.sv
// Self-checking bench for nv_ram_rwsp_prm: directed scenarios plus random traffic against a word-level reference model.
module tb_nv_ram_rwsp_prm;

  localparam int DEPTH = 61;
  localparam int WIDTH = 514;
  localparam int AW    = 6;
`ifdef NV_RAM_RWSP_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [AW-1:0]    ra, wa;
  logic             re, ore, we;
  logic [WIDTH-1:0] di;
  logic [WIDTH-1:0] dout;
  logic             dout_vld, init_busy, oob_err;
  logic [31:0]      pwrbus_ram_pd;

  nv_ram_rwsp_prm #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .ra            (ra),
    .re            (re),
    .ore           (ore),
    .dout          (dout),
    .dout_vld      (dout_vld),
    .wa            (wa),
    .we            (we),
    .di            (di),
    .init_busy     (init_busy),
    .oob_err       (oob_err),
    .pwrbus_ram_pd (pwrbus_ram_pd)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // Reference model: the memory as an array of words plus the observable flags.
  logic [WIDTH-1:0] m_mem [DEPTH];
  int               m_sweep_left;
  int               m_ra_d;
  bit               m_ra_ok, m_ra_ld, m_vld, m_oob;
  logic [WIDTH-1:0] m_dout;

  task automatic model_edge();
    if (rst) begin
      foreach (m_mem[i]) m_mem[i] = '0;
      m_sweep_left = DEPTH;
      m_ra_d = 0; m_ra_ok = 0; m_ra_ld = 0;
      m_dout = '0; m_vld = 0; m_oob = 0;
    end else if (m_sweep_left > 0) begin
      m_sweep_left--;
    end else begin
      if (ore) begin
        if (!m_ra_ok)                              m_dout = '0;
        else if (BYPASS && we && int'(wa) == m_ra_d) m_dout = di;
        else                                       m_dout = m_mem[m_ra_d];
        m_vld = m_ra_ld;
      end
      if (re) begin
        m_ra_d  = int'(ra);
        m_ra_ok = int'(ra) < DEPTH;
        m_ra_ld = 1;
        if (int'(ra) >= DEPTH) m_oob = 1;
      end
      if (we) begin
        if (int'(wa) < DEPTH) m_mem[int'(wa)] = di;
        else                  m_oob = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("dout",      dout,                   m_dout);
    check("dout_vld",  WIDTH'(dout_vld),       WIDTH'(m_vld));
    check("init_busy", WIDTH'(init_busy),      WIDTH'(m_sweep_left > 0));
    check("oob_err",   WIDTH'(oob_err),        WIDTH'(m_oob));
  endtask

  task automatic idle();
    we = 0; re = 0; ore = 0;
  endtask

  function automatic logic [WIDTH-1:0] rand_word();
    logic [WIDTH-1:0] r = '0;
    for (int i = 0; i < (WIDTH + 31) / 32; i++) r = (r << 32) | WIDTH'($urandom);
    return r;
  endfunction

  task automatic sweep(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (init_busy && n < 200);
    check(tag, WIDTH'(n), WIDTH'(DEPTH));
  endtask

  task automatic write(input int a, input logic [WIDTH-1:0] d);
    idle(); we = 1; wa = AW'(a); di = d; tick(); idle();
  endtask

  task automatic read(input int a);
    idle(); re = 1; ra = AW'(a); tick();
    idle(); ore = 1; tick(); idle();
  endtask

  initial begin
    pwrbus_ram_pd = $urandom;
    rst = 1; ra = '0; wa = '0; di = '0; idle();
    repeat (3) tick();
    check("rst_dout", dout, '0);
    check("rst_busy", WIDTH'(init_busy), WIDTH'(1));

    // Init sweep with a write that must be ignored.
    rst = 0; we = 1; wa = 5; di = WIDTH'(3); re = 1; ore = 1;
    sweep("init_len");
    read(5);
    check("init_rd5", dout, '0);
    check("init_vld", WIDTH'(dout_vld), WIDTH'(1));

    // Basic latency and hold.
    write(7, WIDTH'(8'hA5));
    re = 1; ra = 7; tick(); idle();
    ore = 1; tick(); idle();
    check("lat_dout", dout, WIDTH'(8'hA5));
    repeat (2) tick();
    check("hold_dout", dout, WIDTH'(8'hA5));

    // Collision of ore with a write to ra_d.
    write(9, WIDTH'(8'h11));
    re = 1; ra = 9; tick(); idle();
    ore = 1; we = 1; wa = 9; di = WIDTH'(8'h22); tick(); idle();
    check("coll_dout", dout, BYPASS ? WIDTH'(8'h22) : WIDTH'(8'h11));
    read(9);
    check("coll_reread", dout, WIDTH'(8'h22));

    // Out-of-range accesses.
    check("oob_pre", WIDTH'(oob_err), WIDTH'(0));
    write(61, WIDTH'(8'h77));
    check("oob_wr", WIDTH'(oob_err), WIDTH'(1));
    read(63);
    check("oob_rd", dout, '0);

    // Random traffic.
    for (int c = 0; c < 500; c++) begin
      we  = 1'($urandom);
      re  = 1'($urandom);
      ore = 1'($urandom);
      wa  = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(DEPTH, 63)) : AW'($urandom_range(0, DEPTH - 1));
      ra  = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(DEPTH, 63)) : AW'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 3) == 0) ra = wa;
      di  = rand_word();
      tick();
    end
    idle();
    check("oob_sticky", WIDTH'(oob_err), WIDTH'(1));

    // Reset mid-run.
    write(0, WIDTH'(8'hFF));
    rst = 1; tick();
    check("mid_dout", dout, '0);
    check("mid_vld",  WIDTH'(dout_vld), WIDTH'(0));
    check("mid_busy", WIDTH'(init_busy), WIDTH'(1));
    check("mid_oob",  WIDTH'(oob_err), WIDTH'(0));
    rst = 0;
    sweep("mid_len");

    // Stale output register: ore without any prior re.
    ore = 1; tick(); idle();
    check("stale_vld", WIDTH'(dout_vld), WIDTH'(0));
    read(0);
    check("mid_rd0", dout, '0);
    check("mid_rd0_vld", WIDTH'(dout_vld), WIDTH'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
